// File: rtl/mcpu_ram_ctrl_sync.sv
// MicroCPU RAM controller: one word-organised array shared by a byte-enabled data port
// and a read-only fetch port, both with registered one-cycle read latency.
module mcpu_ram_ctrl_sync #(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          RAM_SIZE   = 256,
  parameter logic [WORD_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_WIDTH-1:0]  d_addr,
  input  logic [WORD_SIZE-1:0]   d_wdata,
  input  logic [WORD_SIZE/8-1:0] d_be,
  output logic                   d_ready,
  output logic                   d_rvalid,
  output logic [WORD_SIZE-1:0]   d_rdata,
  input  logic                   i_req,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic                   i_rvalid,
  output logic [WORD_SIZE-1:0]   i_rdata,
  output logic                   init_done
);

  localparam int unsigned           BE_W      = WORD_SIZE / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  reg [WORD_SIZE-1:0] mem [RAM_SIZE-1:0];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [WORD_SIZE-1:0]  d_rdata_q, d_rdata_d;
  logic                  i_rvalid_q, i_rvalid_d;
  logic [WORD_SIZE-1:0]  i_rdata_q, i_rdata_d;

  logic running;
  logic d_rd_en;
  logic d_wr_en;
  logic i_rd_en;

  assign running   = (state_q == RUN);
  assign d_rd_en   = d_req & ~d_we & running;
  assign d_wr_en   = d_req &  d_we & running;
  assign i_rd_en   = i_req & running;

  assign d_ready   = running;
  assign init_done = running;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;

  // Read data is captured from the array before this edge's write lands, giving read-before-write.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_rvalid_d = d_rd_en;
    d_rdata_d  = d_rdata_q;
    i_rvalid_d = i_rd_en;
    i_rdata_d  = i_rdata_q;

    if (d_rd_en) d_rdata_d = mem[d_addr];
    if (i_rd_en) i_rdata_d = mem[i_addr];

    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      i_rdata_q  <= i_rdata_d;
    end
  end

  // The array itself has no reset; the sweep rewrites it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem[cnt_q] <= INIT_VALUE;
      end else if (d_wr_en) begin
        for (int k = 0; k < BE_W; k++) begin
          if (d_be[k]) mem[d_addr][8*k +: 8] <= d_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mcpu_ram_ctrl_sync.sv
// Directed and random bench for mcpu_ram_ctrl_sync; a shadow memory model feeds per-port
// scoreboard queues that are popped as read data comes back.
module tb_mcpu_ram_ctrl_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_req, d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic [1:0]  d_be;
  logic        d_ready, d_rvalid;
  logic [15:0] d_rdata;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_rvalid;
  logic [15:0] i_rdata;
  logic        init_done;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] model [256];
  logic [15:0] dq [$];
  logic [15:0] iq [$];
  logic [15:0] lastD, lastI;
  bit          tbRun;
  bit          expD, expI;

  always #5 clk = ~clk;

  mcpu_ram_ctrl_sync #(
    .WORD_SIZE (16),
    .ADDR_WIDTH(8),
    .RAM_SIZE  (256),
    .INIT_VALUE(16'h0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_ready  (d_ready),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .init_done(init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    if (expD) begin
      check("d_rvalid", d_rvalid, 1);
      if (dq.size() > 0) begin
        lastD = dq.pop_front();
        check("d_rdata", d_rdata, lastD);
      end
    end else begin
      check("d_rvalid_idle", d_rvalid, 0);
      check("d_rdata_hold", d_rdata, lastD);
    end
    if (expI) begin
      check("i_rvalid", i_rvalid, 1);
      if (iq.size() > 0) begin
        lastI = iq.pop_front();
        check("i_rdata", i_rdata, lastI);
      end
    end else begin
      check("i_rvalid_idle", i_rvalid, 0);
      check("i_rdata_hold", i_rdata, lastI);
    end
  endtask

  task automatic applyStimulus(input logic dreq, input logic dwe, input logic [7:0] daddr,
                               input logic [15:0] wdata, input logic [1:0] be,
                               input logic ireq, input logic [7:0] iaddr);
    d_req   = dreq;
    d_we    = dwe;
    d_addr  = daddr;
    d_wdata = wdata;
    d_be    = be;
    i_req   = ireq;
    i_addr  = iaddr;
    expD = tbRun && dreq && !dwe;
    expI = tbRun && ireq;
    if (expD) dq.push_back(model[daddr]);
    if (expI) iq.push_back(model[iaddr]);
    if (tbRun && dreq && dwe) begin
      for (int k = 0; k < 2; k++) begin
        if (be[k]) model[daddr][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic waitSweep(input string tag);
    int  cyc = 0;
    bit  sawIvalid = 0;
    bit  sawDvalid = 0;
    bit  badReady = 0;
    int  bad = 0;
    while (init_done !== 1'b1 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (i_rvalid !== 1'b0) sawIvalid = 1;
      if (d_rvalid !== 1'b0) sawDvalid = 1;
      if (init_done !== 1'b1 && d_ready !== 1'b0) badReady = 1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check({tag, "_init_latency"}, cyc, 256);
    check({tag, "_i_rvalid_in_clear"}, sawIvalid, 0);
    check({tag, "_d_rvalid_in_clear"}, sawDvalid, 0);
    check({tag, "_d_ready_in_clear"}, badReady, 0);
    check({tag, "_d_ready_run"}, d_ready, 1);
    for (int i = 0; i < 256; i++) begin
      if (dut.mem[i] !== 16'h0000) bad++;
      model[i] = 16'h0000;
    end
    check({tag, "_sweep_zero"}, bad, 0);
    tbRun = 1;
  endtask

  initial begin
    tbRun = 0;
    expD = 0;
    expI = 0;
    rst_n = 1'b0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    i_req = 0; i_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d_ready", d_ready, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_init_done", init_done, 0);
    lastD = 16'h0000;
    lastI = 16'h0000;

    // Fetches issued during the sweep must be dropped.
    i_req  = 1'b1;
    i_addr = 8'd3;
    rst_n  = 1'b1;
    waitSweep("sweep1");

    for (int a = 0; a < 256; a++)
      applyStimulus(1, 1, 8'(a), 16'h0FAC, 2'b11, 0, 8'h00);
    for (int a = 0; a <= 256; a++)
      applyStimulus(1, 0, 8'(a), 16'h0000, 2'b00, 1, 8'(a));

    applyStimulus(1, 1, 8'd5, 16'hAAAA, 2'b11, 0, 8'h00);
    applyStimulus(1, 1, 8'd5, 16'h1234, 2'b01, 0, 8'h00);
    applyStimulus(1, 0, 8'd5, 16'h0000, 2'b00, 1, 8'd5);
    check("partial_be_lo", lastD, 16'hAA34);

    applyStimulus(1, 1, 8'd6, 16'h5678, 2'b10, 0, 8'h00);
    applyStimulus(1, 1, 8'd7, 16'hFFFF, 2'b00, 0, 8'h00);
    applyStimulus(1, 0, 8'd6, 16'h0000, 2'b00, 1, 8'd7);
    check("partial_be_hi", lastD, 16'h56AC);
    check("be_zero_noop", lastI, 16'h0FAC);

    applyStimulus(1, 1, 8'd9, 16'hBEEF, 2'b11, 1, 8'd9);
    check("rbw_old", lastI, 16'h0FAC);
    applyStimulus(0, 0, 8'd0, 16'h0000, 2'b00, 1, 8'd9);
    check("rbw_new", lastI, 16'hBEEF);

    applyStimulus(1, 0, 8'd9, 16'h0000, 2'b00, 0, 8'h00);
    applyStimulus(0, 0, 8'd0, 16'h0000, 2'b00, 0, 8'h00);
    applyStimulus(0, 0, 8'd0, 16'h0000, 2'b00, 0, 8'h00);

    for (int n = 0; n < 400; n++) begin
      logic        rq, we, iq_r;
      logic [7:0]  da, ia;
      logic [15:0] wd;
      logic [1:0]  be;
      rq   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      iq_r = 1'($urandom_range(0, 1));
      da   = 8'($urandom_range(0, 15));
      ia   = 8'($urandom_range(0, 15));
      wd   = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      applyStimulus(rq, we, da, wd, be, iq_r, ia);
    end

    // A read presented on the reset edge must not come back.
    tbRun   = 0;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 8'd5;
    i_req   = 1'b1;
    i_addr  = 8'd5;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_d_rvalid", d_rvalid, 0);
    check("rst2_i_rvalid", i_rvalid, 0);
    check("rst2_init_done", init_done, 0);
    check("rst2_d_ready", d_ready, 0);
    check("rst2_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    d_req = 1'b0;
    i_req = 1'b0;
    dq.delete();
    iq.delete();
    lastD = 16'h0000;
    lastI = 16'h0000;
    waitSweep("sweep2");

    applyStimulus(1, 0, 8'd5, 16'h0000, 2'b00, 1, 8'd9);
    check("post_reset_d", lastD, 16'h0000);
    check("post_reset_i", lastI, 16'h0000);
    applyStimulus(0, 0, 8'd0, 16'h0000, 2'b00, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
